// File: rtl/ldpc_syndrome_ctrl.sv
// Iteration controller for the LDPC decoder: computes the parity syndrome of each
// hard-decision vector, decides early termination / MAX_ITER stop, and emits the frame.
module ldpc_syndrome_ctrl #(
    parameter int N        = 10,
    parameter int M        = 5,
    // Row m occupies bits [m*N +: N]; rows 0..4 are {0,1,2,3},{0,4,5,6},{1,4,7,8},{2,5,7,9},{3,6,8,9}
    parameter logic [M*N-1:0] H = {10'b1101001000, 10'b1010100100, 10'b0110010010,
                                   10'b0001110001, 10'b0000001111},
    parameter int MAX_ITER = 10,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              iter_valid,
    input  logic [N-1:0]      corrected_seq,
    output logic              decoder_en,
    output logic [M-1:0]      syndrome,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              out_converged,
    output logic [ITER_W-1:0] out_iters,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
    logic [N-1:0]        seq_q, seq_d;
    logic [M-1:0]        syndrome_q, syndrome_d;
    logic                dec_en_q, dec_en_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [N-1:0]        out_data_q, out_data_d;
    logic                out_conv_q, out_conv_d;
    logic [ITER_W-1:0]   out_iters_q, out_iters_d;
    logic [M-1:0]        syndrome_calc;

    function automatic logic [M-1:0] calc_syndrome(input logic [N-1:0] seq);
        logic [M-1:0] s;
        s = '0;
        for (int m = 0; m < M; m++) begin
            s[m] = ^(H[m*N +: N] & seq);
        end
        return s;
    endfunction

    assign syndrome_calc = calc_syndrome(corrected_seq);

    // Output handshake: the frame transfers on the first rising edge where out_valid
    // and out_ready are both high; until then out_valid and the frame fields hold steady.
    always_comb begin
        state_d     = state_q;
        iter_cnt_d  = iter_cnt_q;
        seq_d       = seq_q;
        syndrome_d  = syndrome_q;
        dec_en_d    = dec_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_conv_d  = out_conv_q;
        out_iters_d = out_iters_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    iter_cnt_d = '0;
                    dec_en_d   = 1'b1;
                end
            end
            RUN: begin
                if (iter_valid) begin
                    state_d    = CHECK;
                    seq_d      = corrected_seq;
                    syndrome_d = syndrome_calc;
                    iter_cnt_d = iter_cnt_q + 1'b1;
                    dec_en_d   = 1'b0;
                end
            end
            CHECK: begin
                if (syndrome_q == '0 || iter_cnt_q == ITER_W'(MAX_ITER)) begin
                    state_d     = OUT;
                    out_conv_d  = (syndrome_q == '0);
                    out_data_d  = seq_q;
                    out_iters_d = iter_cnt_q;
                    out_valid_d = 1'b1;
                end else begin
                    state_d  = RUN;
                    dec_en_d = 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iter_cnt_q  <= '0;
            seq_q       <= '0;
            syndrome_q  <= '0;
            dec_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_conv_q  <= 1'b0;
            out_iters_q <= '0;
        end else begin
            state_q     <= state_d;
            iter_cnt_q  <= iter_cnt_d;
            seq_q       <= seq_d;
            syndrome_q  <= syndrome_d;
            dec_en_q    <= dec_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_conv_q  <= out_conv_d;
            out_iters_q <= out_iters_d;
        end
    end

    assign decoder_en    = dec_en_q;
    assign syndrome      = syndrome_q;
    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_converged = out_conv_q;
    assign out_iters     = out_iters_q;
    assign state_o       = state_q;

endmodule
